// File: rtl/event_onehot_scheduler.sv
// event_onehot_scheduler
//   Captures rising edges on N event lines as pending requests and issues
//   them one at a time, round-robin, as a one-hot word with valid/ready.
//   The output word is always one-hot (out_valid=1) or all-zero.
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : 1 = capture edges and issue grants, 0 = freeze both
//   req_in     : event lines (synchronous to clk)
//   out_onehot : granted event, one-hot when out_valid, else zero
//   out_valid  : out_onehot holds an unaccepted event
//   out_ready  : consumer accepts on out_valid & out_ready
//   pending    : captured events not yet moved to the output register
//   overflow   : one-cycle pulse, an edge hit a line already pending
module event_onehot_scheduler #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] out_onehot,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]  r_req_q;
  logic [N-1:0]  r_pending;
  logic [N-1:0]  r_out_onehot;
  logic          r_out_valid;
  logic          r_overflow;
  logic [IW-1:0] r_last;

  logic [N-1:0]  w_rise;
  logic          w_load;
  logic          w_found;
  logic [IW-1:0] w_sel_idx;
  logic [IW-1:0] w_idx;
  logic [N-1:0]  w_sel_onehot;
  logic [N-1:0]  w_clr;
  logic          w_collide;

  assign w_rise = req_in & ~r_req_q;
  assign w_load = en && (!r_out_valid || out_ready) && (r_pending != '0);

  // Round-robin search starting at last+1; the index wraps naturally
  // because N is a power of two (k = N revisits 'last' itself).
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_idx     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = r_last + IW'(k);
      if (!w_found && r_pending[w_idx]) begin
        w_found   = 1'b1;
        w_sel_idx = w_idx;
      end
    end
    w_sel_onehot = w_found ? (N'(1) << w_sel_idx) : '0;
  end

  assign w_clr     = w_load ? w_sel_onehot : '0;
  // A rise on the bit being loaded this cycle re-arms it, not an overflow.
  assign w_collide = en && ((w_rise & r_pending & ~w_clr) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q      <= '0;
      r_pending    <= '0;
      r_out_onehot <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_last       <= IW'(N - 1);
    end else begin
      r_req_q    <= req_in;
      r_overflow <= w_collide;
      if (en) begin
        r_pending <= (r_pending & ~w_clr) | w_rise;
      end
      if (w_load) begin
        r_out_onehot <= w_sel_onehot;
        r_out_valid  <= 1'b1;
        r_last       <= w_sel_idx;
      end else if (r_out_valid && out_ready) begin
        r_out_onehot <= '0;
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_onehot = r_out_onehot;
  assign out_valid  = r_out_valid;
  assign pending    = r_pending;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_event_onehot_scheduler.sv
// Self-checking bench for event_onehot_scheduler: expected grants are queued
// as events are driven and popped when the DUT hands a word to the consumer.
module tb_event_onehot_scheduler;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req_in;
  logic [7:0] out_onehot;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       overflow;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [7:0]  exp_q[$];

  event_onehot_scheduler #(.N(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req_in     (req_in),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pending    (pending),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer side: a word is taken on the coming edge when valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected", {24'h0, out_onehot}, 32'h0);
      end else begin
        check_eq("sb_grant", {24'h0, out_onehot}, {24'h0, exp_q.pop_front()});
        check_eq("sb_onehot", $countones(out_onehot), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    en        = 1'b0;
    req_in    = '0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_onehot", {24'h0, out_onehot}, 32'h0);
    check_eq("rst_valid", {31'h0, out_valid}, 32'h0);
    check_eq("rst_pending", {24'h0, pending}, 32'h0);
    check_eq("rst_overflow", {31'h0, overflow}, 32'h0);
    rst_n = 1'b1;

    // Single event: two-clock latency, edge-only capture.
    en = 1'b1; out_ready = 1'b1;
    tick();
    req_in = 8'h10; exp_q.push_back(8'h10);
    tick();
    check_eq("t1_pending", {24'h0, pending}, 32'h10);
    check_eq("t1_valid0", {31'h0, out_valid}, 32'h0);
    tick();
    check_eq("t1_valid1", {31'h0, out_valid}, 32'h1);
    check_eq("t1_pend_clr", {24'h0, pending}, 32'h0);
    tick();
    check_eq("t1_drop", {31'h0, out_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t1_norepeat", {31'h0, out_valid}, 32'h0);
    end
    req_in = '0;
    tick();

    // Round-robin wrap from a fresh reset (last = 7).
    @(posedge clk); #3 rst_n = 1'b0; #4 rst_n = 1'b1;
    tick();
    req_in = 8'h83;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h80);
    tick();
    check_eq("t2_pending", {24'h0, pending}, 32'h83);
    req_in = '0;
    tick();
    check_eq("t2_pend1", {24'h0, pending}, 32'h82);
    tick();
    tick();
    check_eq("t2_pend3", {24'h0, pending}, 32'h0);
    tick();
    check_eq("t2_idle", {31'h0, out_valid}, 32'h0);
    req_in = 8'h01; exp_q.push_back(8'h01);
    tick();
    req_in = '0;
    tick();
    check_eq("t2_rearm", {24'h0, out_onehot}, 32'h01);
    tick();
    check_eq("t2_idle2", {31'h0, out_valid}, 32'h0);

    // Backpressure.
    out_ready = 1'b0;
    req_in = 8'h24; exp_q.push_back(8'h04); exp_q.push_back(8'h20);
    tick();
    req_in = '0;
    tick();
    tick();
    tick();
    check_eq("t3_hold", {24'h0, out_onehot}, 32'h04);
    check_eq("t3_holdv", {31'h0, out_valid}, 32'h1);
    check_eq("t3_pending", {24'h0, pending}, 32'h20);
    out_ready = 1'b1;
    tick();
    check_eq("t3_next", {24'h0, out_onehot}, 32'h20);
    tick();
    check_eq("t3_idle", {31'h0, out_valid}, 32'h0);

    // Overflow, then a rise coincident with its own load.
    out_ready = 1'b0;
    req_in = 8'h09; exp_q.push_back(8'h01);
    tick();
    req_in = '0;
    tick();
    check_eq("t4_pend8", {24'h0, pending}, 32'h08);
    req_in = 8'h08;
    tick();
    check_eq("t4_ovf1", {31'h0, overflow}, 32'h1);
    check_eq("t4_pend_keep", {24'h0, pending}, 32'h08);
    tick();
    check_eq("t4_ovf_pulse", {31'h0, overflow}, 32'h0);
    req_in = '0;
    tick();
    out_ready = 1'b1; req_in = 8'h08;
    exp_q.push_back(8'h08); exp_q.push_back(8'h08);
    tick();
    check_eq("t4_no_ovf", {31'h0, overflow}, 32'h0);
    check_eq("t4_rearm", {24'h0, pending}, 32'h08);
    req_in = '0;
    tick();
    check_eq("t4_pend0", {24'h0, pending}, 32'h0);
    tick();
    check_eq("t4_idle", {31'h0, out_valid}, 32'h0);

    // Enable gating.
    en = 1'b0; req_in = 8'hFF;
    tick();
    req_in = '0;
    tick();
    check_eq("t5_nocap", {24'h0, pending}, 32'h0);
    check_eq("t5_nogrant", {31'h0, out_valid}, 32'h0);
    en = 1'b1; out_ready = 1'b0;
    req_in = 8'h42; exp_q.push_back(8'h40);
    tick();
    req_in = '0;
    tick();
    check_eq("t5_word", {24'h0, out_onehot}, 32'h40);
    en = 1'b0; out_ready = 1'b1;
    tick();
    check_eq("t5_accept", {31'h0, out_valid}, 32'h0);
    check_eq("t5_retain", {24'h0, pending}, 32'h02);
    tick();
    check_eq("t5_noload", {31'h0, out_valid}, 32'h0);
    en = 1'b1; exp_q.push_back(8'h02);
    tick();
    tick();
    check_eq("t5_idle", {31'h0, out_valid}, 32'h0);

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    req_in = 8'h10;
    tick();
    req_in = 8'h0F;
    tick();
    check_eq("t6_pending", {24'h0, pending}, 32'h0F);
    check_eq("t6_valid", {31'h0, out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", {31'h0, out_valid}, 32'h0);
    check_eq("t6_rst_onehot", {24'h0, out_onehot}, 32'h0);
    check_eq("t6_rst_pending", {24'h0, pending}, 32'h0);
    req_in = '0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    req_in = 8'h0F;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h04); exp_q.push_back(8'h08);
    tick();
    req_in = '0;
    tick();
    check_eq("t6_first", {24'h0, out_onehot}, 32'h01);
    for (int i = 0; i < 4; i++) tick();
    check_eq("t6_idle", {31'h0, out_valid}, 32'h0);
    check_eq("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/event_onehot_scheduler.md
# event_onehot_scheduler

Upstream stage of the 8-to-3 encoder. Captures rising edges on eight event lines, holds each as a pending request, and presents them one at a time as a one-hot 8-bit word, served round-robin. The word goes to the encoder's `a` input with a valid/ready handshake. Because the output is always one-hot or all-zero, the encoder never sees a multi-bit input.

## Interface
Parameters:
- `N`, 8: number of event lines; fixed at 8 to match the encoder input width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  1 = capture edges and issue grants; 0 = freeze capture and issue.
- `req_in`  in  8  event lines, already synchronous to `clk`.
- `out_onehot`  out  8  granted event, exactly one bit set when `out_valid`=1, else 8'h00.
- `out_valid`  out  1  `out_onehot` holds an unaccepted event.
- `out_ready`  in  1  consumer accepts the word on a cycle with `out_valid`=1 and `out_ready`=1.
- `pending`  out  8  events captured but not yet moved to the output register.
- `overflow`  out  1  one-cycle pulse: an edge arrived on a line already pending.

## Operation
- Edge detect: `req_q` <= `req_in` every cycle, regardless of `en`. `rise[i]` = `req_in[i]` & ~`req_q[i]`.
- Capture, when `en`=1: each `rise[i]` sets `pending[i]`. When `en`=0: rises are discarded and `pending` is held.
- Load condition: `en`=1 and (`out_valid`=0 or `out_ready`=1) and `pending` != 0 (current-cycle register value).
- Load action:
  - Select the first set bit of `pending`, searching from index `last+1` upward and wrapping 7->0.
  - Write that bit one-hot into `out_onehot`, set `out_valid`, clear that `pending` bit, and set `last` to its index.
- Accept with no load (`out_valid` and `out_ready`, but no pending or `en`=0): `out_valid` <= 0, `out_onehot` <= 0.
- Hold: `out_valid`=1 and `out_ready`=0 keeps `out_onehot` stable regardless of `en` or new events.
- Simultaneous set/clear on the same bit: a rise arriving in the cycle that bit is loaded leaves `pending[i]`=1. This is a new event, not an overflow.
- Overflow: a rise on bit i while `pending[i]`=1 and the bit is not being loaded that cycle.
  - The event merges and is lost.
  - `overflow` pulses high for the next cycle, once per cycle no matter how many bits collide.
- `en` 1->0 mid-operation: the output word already issued stays valid until accepted. No further loads. `pending` is retained.

## Timing
- Reset (async assert, synchronous release by clock edges thereafter):
  - `req_q`, `pending`, `out_onehot` = 0
  - `out_valid`, `overflow` = 0
  - `last` = 7, so the first search starts at bit 0.
- Latency, idle block: `req_in[i]` rises before edge k; `pending[i]`=1 after edge k; `out_valid`=1 with the bit after edge k+1. Two clocks total.
- Throughput: one grant per cycle while `out_ready`=1 and `pending` is non-empty.
- Round-robin fairness: a continuously pending line is granted within 8 loads.
- All outputs are registered; none combinationally depends on `out_ready` or `req_in`.
- Reset asserted mid-transfer: the word is dropped and `out_valid` falls immediately (asynchronously).

## Test plan
- Reset then single event:
  - Stimulus: `en`=1, `out_ready`=1, `req_in`=8'h00 -> 8'h10 held high.
  - Required: `pending`=8'h10 after 1 clk; `out_onehot`=8'h10 with `out_valid`=1 after 2 clks. `out_valid` drops the next clk.
  - No repeat grant while `req_in` stays high (edge only).
- Round-robin wrap:
  - Stimulus: `req_in` 0 -> 8'h83 in one cycle, `out_ready`=1.
  - Required: grants 8'h01, 8'h02, 8'h80 on consecutive cycles.
  - Then pulse 8'h01 again -> next grant 8'h01 (search from bit 0 after `last`=7).
- Backpressure:
  - Stimulus: `out_ready`=0 with events 8'h04 and 8'h20 captured.
  - Required: `out_onehot`=8'h04 held stable, `pending`=8'h20. Raise `out_ready` -> 8'h20 on the next cycle, then `out_valid`=0.
- Overflow vs re-arm:
  - Stimulus and response:
    - With `out_ready`=0 and `pending[3]`=1, toggle `req_in[3]` 1->0->1 -> `overflow` = 1 for exactly one clk.
    - Repeat with the new rise coincident with bit 3 being loaded -> `overflow` stays 0 and `pending[3]` stays 1.
- Enable gating:
  - Stimulus: `en`=0, pulse 8'hFF.
  - Required: `pending` stays 8'h00 and no grant. With `en`=0 while a word is valid and `out_ready`=1, the word is accepted and `out_valid` falls; no new load.
- Async reset mid-operation:
  - Stimulus: `pending`=8'h0F, `out_valid`=1, then `rst_n` low between clock edges.
  - Required: all outputs = 0 immediately. After release, the first new event is granted from bit 0 priority.
